// File: rtl/ps2_host_tx_if.sv
// Command/status and pad-level signals of the PS/2 host transmitter.
// The slave modport is the transmitter; master is the system side and pads.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic [1:0] status;
  logic       rx_inhibit;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  modport master (
    output tx_data, tx_start, ps2_clk_i, ps2_data_i,
    input  busy, done, status, rx_inhibit, ps2_clk_oe, ps2_data_oe
  );

  modport slave (
    input  tx_data, tx_start, ps2_clk_i, ps2_data_i,
    output busy, done, status, rx_inhibit, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send,
// shift 8 data bits + odd parity + stop, then collect the device ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYC = 5000,
  parameter int unsigned TIMEOUT_CYC = 750000,
  parameter int unsigned FILTER_LEN  = 8
) (
  input logic          CLK_50MHZ,
  input logic          RESET,
  ps2_host_tx_if.slave bus
);
  localparam int unsigned INH_W = $clog2(INHIBIT_CYC + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_SHIFT     = 3'd2;
  localparam logic [2:0] ST_ACK       = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  logic             clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic             clk_filt_q, fall_q;
  logic [FLT_W-1:0] flt_cnt_q;

  logic [2:0]       state_q, state_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TMO_W-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             par_q, par_d;
  logic             nack_q, nack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       status_q, status_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             timeout_s;

  // Synchronize both pins; the clock level is only accepted after FILTER_LEN equal samples.
  always_ff @(posedge CLK_50MHZ) begin
    if (RESET) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      clk_filt_q  <= 1'b1;
      flt_cnt_q   <= '0;
      fall_q      <= 1'b0;
    end else begin
      clk_meta_q  <= bus.ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= bus.ps2_data_i;
      data_sync_q <= data_meta_q;
      fall_q      <= 1'b0;
      if (clk_sync_q == clk_filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FLT_LAST) begin
        clk_filt_q <= clk_sync_q;
        flt_cnt_q  <= '0;
        fall_q     <= clk_filt_q;
      end else begin
        flt_cnt_q <= flt_cnt_q + FLT_W'(1);
      end
    end
  end

  // Transaction sequencing; a timeout overrides whatever the current state decided.
  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    bit_cnt_d = bit_cnt_q;
    byte_d    = byte_q;
    par_d     = par_q;
    nack_d    = nack_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    status_d  = status_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    timeout_s = 1'b0;

    if (state_q == ST_SHIFT || state_q == ST_ACK || state_q == ST_WAIT_IDLE) begin
      to_cnt_d  = to_cnt_q + TMO_W'(1);
      timeout_s = (to_cnt_q == TMO_LAST);
    end else begin
      timeout_s = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.tx_start) begin
          byte_d    = bus.tx_data;
          par_d     = ~^bus.tx_data;
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          inh_cnt_d = '0;
          state_d   = ST_INHIBIT;
        end else begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          to_cnt_d  = '0;
          bit_cnt_d = 4'd0;
          state_d   = ST_SHIFT;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end
      ST_SHIFT: begin
        if (fall_q) begin
          // The device samples on its rising edge, so each bit is presented right after a fall.
          if (bit_cnt_q < 4'd8) begin
            data_oe_d = ~byte_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            data_oe_d = ~par_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = ST_ACK;
          end
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else begin
          data_oe_d = data_oe_q;
        end
      end
      ST_ACK: begin
        if (fall_q) begin
          nack_d  = data_sync_q;
          state_d = ST_WAIT_IDLE;
        end else begin
          nack_d = nack_q;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_filt_q && data_sync_q) begin
          done_d   = 1'b1;
          busy_d   = 1'b0;
          status_d = {1'b0, nack_q};
          state_d  = ST_DONE;
        end else begin
          done_d = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        busy_d    = 1'b0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    if (timeout_s) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      status_d  = 2'b10;
      state_d   = ST_DONE;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK_50MHZ) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      bit_cnt_q <= 4'd0;
      byte_q    <= 8'h00;
      par_q     <= 1'b0;
      nack_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= 2'b00;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      byte_q    <= byte_d;
      par_q     <= par_d;
      nack_q    <= nack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      status_q  <= status_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.status      = status_q;
  assign bus.rx_inhibit  = busy_q;
  assign bus.ps2_clk_oe  = clk_oe_q;
  assign bus.ps2_data_oe = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on wired-AND lines,
// with the expected line frame and status derived from the byte alone.
module tb_ps2_host_tx;
  localparam int INH = 5000;
  localparam int TMO = 2000;
  localparam int FLT = 8;
  localparam int HP  = 40;  // device half-period in system cycles (12.5 kHz scaled down)

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;
  int   n_vec    = 0;
  int   n_err    = 0;
  int   done_cnt = 0;

  ps2_host_tx_if bus();

  assign bus.ps2_clk_i  = ~bus.ps2_clk_oe & dev_clk;
  assign bus.ps2_data_i = ~bus.ps2_data_oe & dev_data;

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .FILTER_LEN(FLT)) dut (
    .CLK_50MHZ (clk),
    .RESET     (rst),
    .bus       (bus.slave)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (bus.done) done_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line-level frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  task automatic dev_run(input int npulse, input logic ack_bit, input bit glitch,
                         output logic [10:0] seen, output int inh_w);
    int t;
    seen  = '0;
    inh_w = 0;
    t     = 0;
    while (!bus.ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
    while (bus.ps2_clk_oe && inh_w < 2 * INH) begin @(negedge clk); inh_w++; end
    repeat (HP) @(negedge clk);
    seen[0] = bus.ps2_data_i;
    for (int p = 1; p <= npulse; p++) begin
      if (p == 11) dev_data = ack_bit;
      dev_clk = 1'b0;
      repeat (HP) @(negedge clk);
      dev_clk = 1'b1;
      if (p == 11) begin
        dev_data = 1'b1;
      end else begin
        seen[p] = bus.ps2_data_i;
        if (glitch) begin
          repeat (HP / 2) @(negedge clk);
          dev_clk = 1'b0;
          repeat (3) @(negedge clk);
          dev_clk = 1'b1;
          repeat (HP / 2 - 3) @(negedge clk);
        end else begin
          repeat (HP) @(negedge clk);
        end
      end
    end
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    bus.tx_data  = b;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
  endtask

  task automatic do_tx(input logic [7:0] b, input logic ack_bit, input bit glitch, input bit extra);
    logic [10:0] seen;
    int w, t, d0;
    d0 = done_cnt;
    start_tx(b);
    check_val("busy_on", bus.busy, 1);
    check_val("rx_inhibit_on", bus.rx_inhibit, 1);
    check_val("clk_oe_on", bus.ps2_clk_oe, 1);
    fork
      dev_run(11, ack_bit, glitch, seen, w);
      if (extra) begin
        for (int k = 0; k < 3; k++) begin
          repeat (1700) @(negedge clk);
          bus.tx_data  = 8'($urandom);
          bus.tx_start = 1'b1;
          @(negedge clk);
          bus.tx_start = 1'b0;
        end
      end
    join
    check_val("inhibit_width", w, INH);
    check_val("frame", seen, frame_of(b));
    t = 0;
    while (!bus.done && t < 200) begin @(negedge clk); t++; end
    check_val("done_seen", bus.done, 1);
    check_val("status", bus.status, {1'b0, ack_bit});
    check_val("oe_at_done", {bus.ps2_clk_oe, bus.ps2_data_oe}, 0);
    check_val("busy_at_done", {bus.busy, bus.rx_inhibit}, 0);
    if (extra) begin
      bus.tx_data  = 8'hA5;
      bus.tx_start = 1'b1;
    end
    @(negedge clk);
    bus.tx_start = 1'b0;
    check_val("busy_after_done", bus.busy, 0);
    repeat (4) @(negedge clk);
    check_val("one_done", done_cnt, d0 + 1);
    check_val("status_hold", bus.status, {1'b0, ack_bit});
  endtask

  initial begin
    logic [10:0] seen, exp_f;
    int w, t, d0;
    logic [7:0] rb;
    logic ra;
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_done", bus.done, 0);
    check_val("rst_status", bus.status, 0);
    check_val("rst_rx_inhibit", bus.rx_inhibit, 0);
    check_val("rst_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_val("idle_busy", bus.busy, 0);

    do_tx(8'hED, 1'b0, 1'b0, 1'b0);
    do_tx(8'hF4, 1'b1, 1'b0, 1'b0);

    // No device response: the transmitter must give up on its own.
    d0 = done_cnt;
    start_tx(8'h3C);
    t = 0;
    while (bus.ps2_clk_oe && t < 2 * INH) begin @(negedge clk); t++; end
    t = 0;
    while (!bus.done && t < 3 * TMO) begin @(negedge clk); t++; end
    check_val("timeout_latency", t, TMO);
    check_val("timeout_status", bus.status, 2'b10);
    check_val("timeout_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 0);
    repeat (4) @(negedge clk);
    check_val("timeout_one_done", done_cnt, d0 + 1);

    do_tx(8'h55, 1'b0, 1'b1, 1'b0);

    // Abort 0xFF part-way through the data bits.
    d0 = done_cnt;
    start_tx(8'hFF);
    dev_run(5, 1'b0, 1'b0, seen, w);
    exp_f = frame_of(8'hFF);
    check_val("rst_partial_frame", seen[5:0], exp_f[5:0]);
    check_val("busy_before_rst", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 0);
    check_val("midrst_busy", {bus.busy, bus.rx_inhibit}, 0);
    repeat (50) @(negedge clk);
    check_val("midrst_no_done", done_cnt, d0);
    do_tx(8'hF4, 1'b0, 1'b0, 1'b0);

    do_tx(8'hED, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom);
      ra = 1'($urandom_range(0, 1));
      do_tx(rb, ra, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: run did not complete within cycle budget");
    $fatal(1);
  end
endmodule
